// File: rtl/mem_arbiter_ctrl_pkg.sv
// Shared definitions for the IF/MEM byte-serialising RAM arbiter.
// Provides bus widths, the active levels used for reset and the write enable,
// the 2-bit FSM state encoding, and the grant encoding.
package mem_arbiter_ctrl_pkg;

  localparam int DATA_BUS = 32;  // word width seen by IF and MEM
  localparam int BYTE_BUS = 8;   // RAM data width

  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic RST_ENABLE   = 1'b1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_MEM = 1'b1
  } gnt_e;

endpackage

// File: rtl/mem_arbiter_ctrl_if.sv
// Bundle of every non-clock signal around mem_arbiter_ctrl: the IF fetch
// port, the MEM data port and the byte-wide RAM port.
//   slave  : the arbiter (takes requests and RAM read data, drives results)
//   master : the environment (pipeline stages plus RAM)
interface mem_arbiter_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  import mem_arbiter_ctrl_pkg::*;

  logic                  if_req_i;
  logic [ADDR_WIDTH-1:0] if_addr_i;
  logic [DATA_BUS-1:0]   if_data_o;
  logic                  if_done_o;

  logic                  mem_req_i;
  logic                  mem_we_i;
  logic [ADDR_WIDTH-1:0] mem_addr_i;
  logic [DATA_BUS-1:0]   mem_data_i;
  logic [3:0]            mem_sel_i;
  logic [DATA_BUS-1:0]   mem_data_o;
  logic                  mem_done_o;

  logic [BYTE_BUS-1:0]   ram_din_i;
  logic [BYTE_BUS-1:0]   ram_dout_o;
  logic [ADDR_WIDTH-1:0] ram_addr_o;
  logic                  ram_wr_o;

  modport slave (
    input  if_req_i, if_addr_i,
    input  mem_req_i, mem_we_i, mem_addr_i, mem_data_i, mem_sel_i,
    input  ram_din_i,
    output if_data_o, if_done_o,
    output mem_data_o, mem_done_o,
    output ram_dout_o, ram_addr_o, ram_wr_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output mem_req_i, mem_we_i, mem_addr_i, mem_data_i, mem_sel_i,
    output ram_din_i,
    input  if_data_o, if_done_o,
    input  mem_data_o, mem_done_o,
    input  ram_dout_o, ram_addr_o, ram_wr_o
  );

endinterface

// File: rtl/mem_arbiter_ctrl_sel_scan.sv
// Combinational byte-enable scanner used by the store sequencer.
//   mask_i : remaining byte-enable mask
//   idx_o  : index of the lowest set bit (0 when the mask is empty)
//   none_o : high when no bit is left
module mem_sel_scan (
  input  logic [3:0] mask_i,
  output logic [1:0] idx_o,
  output logic       none_o
);

  // Walk from the top down so the last hit is the lowest set bit.
  always_comb begin
    idx_o = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask_i[i]) idx_o = 2'(i);
    end
  end

  assign none_o = (mask_i == 4'b0000);

endmodule

// File: rtl/mem_arbiter_ctrl.sv
// Arbiter sharing one byte-wide synchronous RAM between instruction fetch and
// the MEM-stage data port. MEM has fixed priority. Loads and fetches read four
// bytes little-endian; stores write only the bytes enabled in the select mask.
// The winner gets a one-cycle done pulse, followed by a one-cycle DONE state in
// which no grant is made, so a request still held high is not served twice.
// Ports: clk, rst (synchronous, active-high), bus (mem_arbiter_ctrl_if.slave).
// All outputs are registered.
module mem_arbiter_ctrl
  import mem_arbiter_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input logic               clk,
  input logic               rst,
  mem_arbiter_ctrl_if.slave bus
);

  logic [1:0]            state_reg;
  gnt_e                  gnt_reg;
  logic [ADDR_WIDTH-1:0] base_reg;
  logic [DATA_BUS-1:0]   wdata_reg;
  logic [3:0]            mask_reg;
  logic [2:0]            step_reg;
  logic [23:0]           shift_reg;

  logic                  ram_wr_reg;
  logic [ADDR_WIDTH-1:0] ram_addr_reg;
  logic [BYTE_BUS-1:0]   ram_dout_reg;
  logic [DATA_BUS-1:0]   if_data_reg;
  logic [DATA_BUS-1:0]   mem_data_reg;
  logic                  if_done_reg;
  logic                  mem_done_reg;

  // In IDLE the scanner looks at the incoming mask so the first store byte
  // can go out on the granting edge; afterwards it walks the latched mask.
  logic [3:0]            scan_in;
  logic [1:0]            scan_idx;
  logic                  scan_none;
  logic [3:0]            scan_left;
  logic [ADDR_WIDTH-1:0] req_base;

  assign scan_in   = (state_reg == ST_IDLE) ? bus.mem_sel_i : mask_reg;
  assign scan_left = scan_in & ~(4'b0001 << scan_idx);
  assign req_base  = (bus.mem_req_i ? bus.mem_addr_i : bus.if_addr_i)
                     & ~ADDR_WIDTH'(3);

  mem_sel_scan u_sel_scan (
    .mask_i (scan_in),
    .idx_o  (scan_idx),
    .none_o (scan_none)
  );

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_reg    <= ST_IDLE;
      gnt_reg      <= GNT_IF;
      base_reg     <= '0;
      wdata_reg    <= '0;
      mask_reg     <= '0;
      step_reg     <= '0;
      shift_reg    <= '0;
      ram_wr_reg   <= 1'b0;
      ram_addr_reg <= '0;
      ram_dout_reg <= '0;
      if_data_reg  <= '0;
      mem_data_reg <= '0;
      if_done_reg  <= 1'b0;
      mem_done_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.mem_req_i || bus.if_req_i) begin
            base_reg  <= req_base;
            gnt_reg   <= bus.mem_req_i ? GNT_MEM : GNT_IF;
            wdata_reg <= bus.mem_data_i;
            if (bus.mem_req_i && (bus.mem_we_i == WRITE_ENABLE)) begin
              state_reg <= ST_WRITE;
              mask_reg  <= scan_left;
              if (!scan_none) begin
                ram_wr_reg   <= 1'b1;
                ram_addr_reg <= req_base | ADDR_WIDTH'(scan_idx);
                ram_dout_reg <= bus.mem_data_i[{scan_idx, 3'b000} +: BYTE_BUS];
              end
            end else begin
              state_reg    <= ST_READ;
              step_reg     <= 3'd1;
              ram_addr_reg <= req_base;
            end
          end
        end

        // step_reg counts edges since the grant. Addresses go out on steps
        // 0..3; RAM data lags the address by two edges, so bytes arrive on
        // steps 2..5 and the last byte is merged straight from ram_din_i.
        ST_READ: begin
          step_reg <= step_reg + 3'd1;
          if (step_reg <= 3'd3) begin
            ram_addr_reg <= base_reg | ADDR_WIDTH'(step_reg[1:0]);
          end else begin
            ram_addr_reg <= '0;
          end
          if (step_reg >= 3'd2 && step_reg <= 3'd4) begin
            shift_reg <= {bus.ram_din_i, shift_reg[23:8]};
          end
          if (step_reg == 3'd5) begin
            state_reg <= ST_DONE;
            if (gnt_reg == GNT_MEM) begin
              mem_data_reg <= {bus.ram_din_i, shift_reg};
              mem_done_reg <= 1'b1;
            end else begin
              if_data_reg  <= {bus.ram_din_i, shift_reg};
              if_done_reg  <= 1'b1;
            end
          end
        end

        ST_WRITE: begin
          if (scan_none) begin
            ram_wr_reg   <= 1'b0;
            ram_addr_reg <= '0;
            ram_dout_reg <= '0;
            mem_done_reg <= 1'b1;
            state_reg    <= ST_DONE;
          end else begin
            ram_wr_reg   <= 1'b1;
            ram_addr_reg <= base_reg | ADDR_WIDTH'(scan_idx);
            ram_dout_reg <= wdata_reg[{scan_idx, 3'b000} +: BYTE_BUS];
            mask_reg     <= scan_left;
          end
        end

        ST_DONE: begin
          if_done_reg  <= 1'b0;
          mem_done_reg <= 1'b0;
          state_reg    <= ST_IDLE;
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.ram_wr_o   = ram_wr_reg;
  assign bus.ram_addr_o = ram_addr_reg;
  assign bus.ram_dout_o = ram_dout_reg;
  assign bus.if_data_o  = if_data_reg;
  assign bus.mem_data_o = mem_data_reg;
  assign bus.if_done_o  = if_done_reg;
  assign bus.mem_done_o = mem_done_reg;

endmodule
